// File: rtl/mem_stage_if.sv
// Handshake bundle around the MEM stage: EX->MS instruction transfer and MS->WB hand-off.
// slave = the MEM stage itself, master = the surrounding pipeline (EX and WB side).
interface mem_stage_if #(
  parameter int BUS_W = 149
);
  logic             ms_allowin;
  logic             es2ms_valid;
  logic [BUS_W-1:0] es2ms_bus;
  logic [38:0]      es_rf_zip;
  logic             es_mem_req;
  logic [4:0]       es_ld_op;
  logic             es_req_inflight;
  logic             ws_allowin;
  logic             ms2ws_valid;
  logic [BUS_W-1:0] ms2ws_bus;
  logic [38:0]      ms_rf_zip;

  modport master (
    input  ms_allowin,
    output es2ms_valid, es2ms_bus, es_rf_zip, es_mem_req, es_ld_op, es_req_inflight,
    output ws_allowin,
    input  ms2ws_valid, ms2ws_bus, ms_rf_zip
  );

  modport slave (
    output ms_allowin,
    input  es2ms_valid, es2ms_bus, es_rf_zip, es_mem_req, es_ld_op, es_req_inflight,
    input  ws_allowin,
    output ms2ws_valid, ms2ws_bus, ms_rf_zip
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, extends load data, skids it when WB stalls,
// and swallows responses of requests killed by a WB flush. Optional macro MS_LOAD_FWD_EN.
module mem_stage #(
  parameter int BUS_W     = 149,
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  pif,
  output logic [38:0] ms_fwd_zip,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_flush
);
  localparam int CW      = DISCARD_W + 2;
  localparam int CNT_MAX = (1 << DISCARD_W) - 1;

  logic                 ms_valid_q, ms_valid_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;
  logic                 buf_vld_q, buf_vld_d;
  logic [31:0]          buf_q, buf_d;
  logic [BUS_W-1:0]     bus_q, bus_d;
  logic [38:0]          rf_zip_q, rf_zip_d;
  logic                 mem_req_q, mem_req_d;
  logic [4:0]           ld_op_q, ld_op_d;

  logic        resp_ok, ms_ready_go, ms_allowin, ms2ws_valid, load_en, own_lost, ms_ld_pending;
  logic [CW-1:0] cnt_sum;
  logic [31:0] rdata_sel, ld_ext, wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [1:0]  off;

  always_comb begin
    // A response only belongs to MS when no killed request is still ahead of it.
    resp_ok     = data_sram_data_ok & (discard_cnt_q == '0);
    ms_ready_go = ~mem_req_q | buf_vld_q | resp_ok;
    ms_allowin  = ~ms_valid_q | (ms_ready_go & pif.ws_allowin);
    ms2ws_valid = ms_valid_q & ms_ready_go & ~wb_flush;
    load_en     = pif.es2ms_valid & ms_allowin;

    ms_valid_d = ms_valid_q;
    if (wb_flush)        ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = pif.es2ms_valid;

    bus_d     = load_en ? pif.es2ms_bus  : bus_q;
    rf_zip_d  = load_en ? pif.es_rf_zip  : rf_zip_q;
    mem_req_d = load_en ? pif.es_mem_req : mem_req_q;
    ld_op_d   = load_en ? pif.es_ld_op   : ld_op_q;

    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    if (wb_flush || (ms_valid_q && ms_ready_go && pif.ws_allowin)) begin
      buf_vld_d = 1'b0;
    end else if (ms_valid_q && mem_req_q && !buf_vld_q && resp_ok) begin
      buf_vld_d = 1'b1;
      buf_d     = data_sram_rdata;
    end

    own_lost = ms_valid_q & mem_req_q & ~buf_vld_q & ~resp_ok;
    cnt_sum  = CW'(discard_cnt_q);
    if (data_sram_data_ok && discard_cnt_q != '0) cnt_sum = cnt_sum - CW'(1);
    if (wb_flush) cnt_sum = cnt_sum + CW'(own_lost) + CW'(pif.es_req_inflight);
    discard_cnt_d = (cnt_sum > CW'(CNT_MAX)) ? DISCARD_W'(CNT_MAX) : cnt_sum[DISCARD_W-1:0];

    off       = rf_zip_q[1:0];
    rdata_sel = buf_vld_q ? buf_q : data_sram_rdata;
    ld_byte   = rdata_sel[{off, 3'b000} +: 8];
    ld_half   = off[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    ld_ext    = rdata_sel;
    if (ld_op_q[4])      ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op_q[3]) ld_ext = {24'b0, ld_byte};
    else if (ld_op_q[2]) ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (ld_op_q[1]) ld_ext = {16'b0, ld_half};
    wdata = (|ld_op_q) ? ld_ext : rf_zip_q[31:0];

`ifdef MS_LOAD_FWD_EN
    ms_ld_pending = ms_valid_q & (|ld_op_q) & ~ms2ws_valid;
`else
    ms_ld_pending = ms_valid_q & (|ld_op_q);
`endif
  end

  assign pif.ms_allowin  = ms_allowin;
  assign pif.ms2ws_valid = ms2ws_valid;
  assign pif.ms2ws_bus   = bus_q;
  assign pif.ms_rf_zip   = {rf_zip_q[38:32], wdata};
  assign ms_fwd_zip      = {ms_ld_pending, rf_zip_q[37] & ms_valid_q, rf_zip_q[36:32], wdata};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      discard_cnt_q <= '0;
      buf_vld_q     <= 1'b0;
      buf_q         <= '0;
      bus_q         <= '0;
      rf_zip_q      <= '0;
      mem_req_q     <= 1'b0;
      ld_op_q       <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      discard_cnt_q <= discard_cnt_d;
      buf_vld_q     <= buf_vld_d;
      buf_q         <= buf_d;
      bus_q         <= bus_d;
      rf_zip_q      <= rf_zip_d;
      mem_req_q     <= mem_req_d;
      ld_op_q       <= ld_op_d;
    end
  end

  // The system never has more killed requests in flight than the counter holds.
  a_discard_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    cnt_sum <= CW'(CNT_MAX));
endmodule
